// File: rtl/apb_timer_slave_if.sv
// APB bus bundle between a master (bridge or bench) and the timer slave.
interface apb_timer_slave_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_timer_slave.sv
// APB slave with a prescaled 32-bit down-counter timer, programmable wait states
// and a level interrupt.
module apb_timer_slave #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    apb_timer_slave_if.slave   apb,
    output logic               IRQ
);

    localparam logic [2:0] WS        = 3'(WAIT_STATES);
    localparam logic [2:0] ADDR_CTRL = 3'd0;
    localparam logic [2:0] ADDR_LOAD = 3'd1;
    localparam logic [2:0] ADDR_VAL  = 3'd2;
    localparam logic [2:0] ADDR_STAT = 3'd3;
    localparam logic [2:0] ADDR_ID   = 3'd4;

    logic        r_ctrlEn;
    logic        r_ctrlReload;
    logic        r_ctrlIrqEn;
    logic [7:0]  r_prescale;
    logic [31:0] r_load;
    logic [31:0] r_value;
    logic        r_expired;
    logic [7:0]  r_preCnt;
    logic [2:0]  r_waitCnt;

    logic [2:0]  w_addr;
    logic        w_setup;
    logic        w_access;
    logic        w_ready;
    logic        w_wr;
    logic        w_ctrlWr;
    logic        w_loadWr;
    logic        w_statWr;
    logic        w_tickRaw;
    logic        w_tick;
    logic        w_expire;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_addr    = apb.PADDR[4:2];
    assign w_setup   = apb.PSEL & ~apb.PENABLE;
    assign w_access  = apb.PSEL & apb.PENABLE;
    // Gated by reset so the bus sees PREADY low even while the master holds an access.
    assign w_ready   = w_access & (r_waitCnt == 3'd0) & PRESETn;
    assign w_wr      = w_ready & apb.PWRITE;
    assign w_ctrlWr  = w_wr & (w_addr == ADDR_CTRL);
    assign w_loadWr  = w_wr & (w_addr == ADDR_LOAD);
    assign w_statWr  = w_wr & (w_addr == ADDR_STAT);

    // A LOAD write on a tick edge swallows the tick entirely, including any expiry.
    assign w_tickRaw = r_ctrlEn & (r_preCnt == r_prescale);
    assign w_tick    = w_tickRaw & ~w_loadWr;
    assign w_expire  = w_tick & (r_value == 32'd0);

    assign apb.PREADY = w_ready;
    assign apb.PRDATA = w_rdata;
    assign IRQ        = r_expired & r_ctrlIrqEn;
    assign w_unused   = ^{apb.PADDR[31:5], apb.PADDR[1:0]};

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_waitCnt <= 3'd0;
        end else if (w_setup) begin
            r_waitCnt <= WS;
        end else if (w_access && r_waitCnt != 3'd0) begin
            r_waitCnt <= r_waitCnt - 3'd1;
        end
    end

    // Later assignments deliberately override earlier ones: W1C loses to a fresh
    // expiry, and register writes win over the hardware EN clear.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_ctrlEn     <= 1'b0;
            r_ctrlReload <= 1'b0;
            r_ctrlIrqEn  <= 1'b0;
            r_prescale   <= 8'd0;
            r_load       <= 32'd0;
            r_value      <= 32'd0;
            r_expired    <= 1'b0;
            r_preCnt     <= 8'd0;
        end else begin
            if (r_ctrlEn) begin
                r_preCnt <= w_tickRaw ? 8'd0 : r_preCnt + 8'd1;
            end
            if (w_tick) begin
                if (r_value != 32'd0) begin
                    r_value <= r_value - 32'd1;
                end else if (r_ctrlReload) begin
                    r_value <= r_load;
                end else begin
                    r_ctrlEn <= 1'b0;
                end
            end
            if (w_statWr && apb.PWDATA[0]) begin
                r_expired <= 1'b0;
            end
            if (w_expire) begin
                r_expired <= 1'b1;
            end
            if (w_ctrlWr) begin
                r_ctrlEn     <= apb.PWDATA[0];
                r_ctrlReload <= apb.PWDATA[1];
                r_ctrlIrqEn  <= apb.PWDATA[2];
                r_prescale   <= apb.PWDATA[15:8];
                if (!r_ctrlEn && apb.PWDATA[0]) begin
                    r_preCnt <= 8'd0;
                end
            end
            if (w_loadWr) begin
                r_load   <= apb.PWDATA;
                r_value  <= apb.PWDATA;
                r_preCnt <= 8'd0;
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (PRESETn && apb.PSEL && !apb.PWRITE) begin
            case (w_addr)
                ADDR_CTRL: w_rdata = {16'd0, r_prescale, 5'd0, r_ctrlIrqEn, r_ctrlReload, r_ctrlEn};
                ADDR_LOAD: w_rdata = r_load;
                ADDR_VAL:  w_rdata = r_value;
                ADDR_STAT: w_rdata = {31'd0, r_expired};
                ADDR_ID:   w_rdata = ID_VALUE;
                default:   w_rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: directed APB/timer scenarios plus
// randomized timer runs checked against a closed-form tick/expiry model.
module tb_apb_timer_slave;

    localparam int          WS      = 1;
    localparam logic [31:0] ID_EXP  = 32'hA9B0_0001;
    localparam logic [31:0] A_CTRL  = 32'h00;
    localparam logic [31:0] A_LOAD  = 32'h04;
    localparam logic [31:0] A_VALUE = 32'h08;
    localparam logic [31:0] A_STAT  = 32'h0C;
    localparam logic [31:0] A_ID    = 32'h10;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b1;
    logic IRQ;

    apb_timer_slave_if bus();

    apb_timer_slave #(.WAIT_STATES(WS), .ID_VALUE(ID_EXP)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (bus),
        .IRQ     (IRQ)
    );

    always #5 PCLK = ~PCLK;

    int cycleCount = 0;
    always @(posedge PCLK) cycleCount <= cycleCount + 1;

    int   tests     = 0;
    int   failures  = 0;
    int   lastCycle = 0;
    logic lastIrq   = 1'b0;
    int   lastWaits = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer; entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input bit write, input logic [31:0] addr, input logic [31:0] data,
                                 output logic [31:0] rdata);
        bit done = 1'b0;
        rdata       = 32'd0;
        lastWaits   = 0;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = write;
        bus.PADDR   = addr;
        bus.PWDATA  = data;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge PCLK);
            if (bus.PREADY === 1'b1) begin
                rdata     = bus.PRDATA;
                lastCycle = cycleCount;
                lastIrq   = IRQ;
                done      = 1'b1;
                break;
            end
            lastWaits++;
            @(posedge PCLK); #1;
        end
        if (!done) begin
            tests++;
            failures++;
            $error("[TB] FAIL preadyTimeout observed=%h expected=%h", 1'b0, 1'b1);
        end
        @(posedge PCLK); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic apbWrite(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        applyStimulus(1'b1, addr, data, dummy);
    endtask

    task automatic apbRead(input logic [31:0] addr, output logic [31:0] data);
        applyStimulus(1'b0, addr, 32'd0, data);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge PCLK); #1; end
    endtask

    task automatic waitUntil(input int target);
        while (cycleCount < target) begin @(posedge PCLK); #1; end
    endtask

    // t edges after VALUE=L and the prescaler were freshly started, k = t/(P+1)
    // ticks have fired; expiry happens on every (L+1)-th tick.
    function automatic void modelTimer(input int t, input int L, input int P, input bit rl,
                                       output int v, output bit ex, output bit en);
        int k = t / (P + 1);
        if (rl) begin
            v  = L - (k % (L + 1));
            ex = (k >= L + 1);
            en = 1'b1;
        end else if (k >= L + 1) begin
            v  = 0;
            ex = 1'b1;
            en = 1'b0;
        end else begin
            v  = L - k;
            ex = 1'b0;
            en = 1'b1;
        end
    endfunction

    task automatic runTrial(input int L, input int P, input bit rl, input bit ie,
                            input int samples, input int maxGap);
        logic [31:0] rd;
        logic [31:0] ctrlWord;
        int en0, v;
        bit ex, en;
        apbWrite(A_CTRL, 32'd0);
        apbWrite(A_STAT, 32'd1);
        apbWrite(A_LOAD, 32'(L));
        ctrlWord = {16'd0, P[7:0], 5'd0, ie, rl, 1'b1};
        apbWrite(A_CTRL, ctrlWord);
        en0 = cycleCount;
        for (int s = 0; s < samples; s++) begin
            idle($urandom_range(0, maxGap));
            apbRead(A_VALUE, rd);
            modelTimer(lastCycle - en0, L, P, rl, v, ex, en);
            checkOutput("trialValue", rd, 32'(v));
            apbRead(A_STAT, rd);
            modelTimer(lastCycle - en0, L, P, rl, v, ex, en);
            checkOutput("trialExpired", rd, {31'd0, ex});
            checkOutput("trialIrq", {31'd0, lastIrq}, {31'd0, ex & ie});
            apbRead(A_CTRL, rd);
            modelTimer(lastCycle - en0, L, P, rl, v, ex, en);
            checkOutput("trialCtrl", rd, {ctrlWord[31:1], en});
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int en0, v;
        bit ex, en;

        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 32'd0;
        bus.PWDATA  = 32'd0;

        // Reset with a read access held on the bus: outputs must stay low.
        #1 PRESETn = 1'b0;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PADDR = A_ID;
        #12;
        checkOutput("resetPready", {31'd0, bus.PREADY}, 32'd0);
        checkOutput("resetPrdata", bus.PRDATA, 32'd0);
        checkOutput("resetIrq", {31'd0, IRQ}, 32'd0);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PADDR = 32'd0;
        @(negedge PCLK); PRESETn = 1'b1;
        @(posedge PCLK); #1;

        apbRead(A_ID, rd);
        checkOutput("idData", rd, ID_EXP);
        checkOutput("idWaits", 32'(lastWaits), 32'(WS));
        apbRead(A_CTRL, rd);   checkOutput("resetCtrl", rd, 32'd0);
        apbRead(A_LOAD, rd);   checkOutput("resetLoad", rd, 32'd0);
        apbRead(A_VALUE, rd);  checkOutput("resetValue", rd, 32'd0);
        apbRead(A_STAT, rd);   checkOutput("resetStatus", rd, 32'd0);

        // Unmapped offsets and the read-only VALUE register.
        apbWrite(A_LOAD, 32'h12);
        apbWrite(32'h14, 32'hFFFF_FFFF);
        apbWrite(32'h1C, 32'hFFFF_FFFF);
        apbWrite(A_VALUE, 32'h77);
        apbRead(32'h14, rd);   checkOutput("read14", rd, 32'd0);
        apbRead(32'h1C, rd);   checkOutput("read1C", rd, 32'd0);
        apbRead(A_LOAD, rd);   checkOutput("loadKept", rd, 32'h12);
        apbRead(A_VALUE, rd);  checkOutput("valueKept", rd, 32'h12);
        apbRead(A_CTRL, rd);   checkOutput("ctrlKept", rd, 32'd0);
        apbRead(A_STAT, rd);   checkOutput("statusKept", rd, 32'd0);

        // Auto-reload, PRESCALE=0, LOAD=3: expiry on edges en0+4, +8, +12, +16.
        apbWrite(A_LOAD, 32'd3);
        apbWrite(A_CTRL, 32'h0000_0007);
        en0 = cycleCount;
        waitUntil(en0 + 7);
        checkOutput("irqBeforeClear", {31'd0, IRQ}, 32'd1);
        apbWrite(A_STAT, 32'd1);
        checkOutput("irqAfterClear", {31'd0, IRQ}, 32'd0);
        waitUntil(en0 + 13);
        apbWrite(A_STAT, 32'd1);
        checkOutput("irqClearOnExpiryEdge", {31'd0, IRQ}, 32'd1);

        // Every edge is a tick here, so this LOAD write lands on one.
        apbWrite(A_LOAD, 32'd9);
        en0 = cycleCount;
        apbRead(A_VALUE, rd);
        modelTimer(lastCycle - en0, 9, 0, 1'b1, v, ex, en);
        checkOutput("loadOnTick", rd, 32'(v));

        runTrial(2, 4, 1'b0, 1'b0, 4, 6);
        for (int i = 0; i < 8; i++) begin
            runTrial(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3, 8);
        end

        // Reset in the wait state of a LOAD write.
        apbWrite(A_CTRL, 32'd0);
        apbWrite(A_LOAD, 32'd0);
        apbWrite(A_CTRL, 32'h0000_0007);
        idle(2);
        checkOutput("irqBeforeReset", {31'd0, IRQ}, 32'd1);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = A_LOAD; bus.PWDATA = 32'hDEAD;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        #2;
        checkOutput("waitStatePready", {31'd0, bus.PREADY}, 32'd0);
        PRESETn = 1'b0;
        #1;
        checkOutput("midResetPready", {31'd0, bus.PREADY}, 32'd0);
        checkOutput("midResetPrdata", bus.PRDATA, 32'd0);
        checkOutput("midResetIrq", {31'd0, IRQ}, 32'd0);
        @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        @(posedge PCLK); #1;
        apbRead(A_LOAD, rd);   checkOutput("loadAfterReset", rd, 32'd0);
        apbRead(A_CTRL, rd);   checkOutput("ctrlAfterReset", rd, 32'd0);
        apbWrite(A_LOAD, 32'h55);
        apbRead(A_LOAD, rd);   checkOutput("loadFresh", rd, 32'h55);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
